// File: rtl/proc_pkg.sv
// Shared processor definitions: fetch FSM state encoding and the
// instruction / program-counter widths used by the IR and control unit.
package proc_pkg;

    localparam int INSTR_W = 16;
    localparam int PC_W    = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        WAIT  = 2'd2,
        WRITE = 2'd3
    } fetch_state_t;

endpackage : proc_pkg

// File: rtl/instr_fetch_unit_if.sv
// Instruction memory read port seen by the fetch unit.
// master: the fetch unit (issues strobe/address, receives data/valid).
// slave:  the instruction memory.
interface instr_fetch_unit_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 8
);

    logic              mem_rd_en;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_data;
    logic              mem_valid;

    modport master (
        output mem_rd_en,
        output mem_addr,
        input  mem_data,
        input  mem_valid
    );

    modport slave (
        input  mem_rd_en,
        input  mem_addr,
        output mem_data,
        output mem_valid
    );

endinterface : instr_fetch_unit_if

// File: rtl/instr_fetch_unit_pc_counter.sv
// Program counter: load/increment register, load wins over increment,
// increment wraps modulo 2^W.
module pc_counter #(
    parameter int W = 8
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         inc,
    output logic [W-1:0] pc
);

    // PC register with synchronous reset; load has priority over increment.
    always_ff @(posedge clock) begin
        // NOTE: non-blocking assignments keep every register sampling the
        // pre-edge value, so ordering between always_ff blocks never matters.
        if (reset) begin
            pc <= '0;
        end else if (load) begin
            pc <= load_val;
        end else if (inc) begin
            pc <= pc + 1'b1;
        end
    end

endmodule : pc_counter

// File: rtl/instr_fetch_unit.sv
// Instruction fetch sequencer: reads one word at pc from instruction memory
// and writes it into the IR with a single-cycle enable, then advances pc.
// Optional wait-state timeout is enabled by defining IFETCH_TIMEOUT_EN.
module instr_fetch_unit
    import proc_pkg::*;
#(
    parameter int DATA_W = INSTR_W,
    parameter int ADDR_W = PC_W
`ifdef IFETCH_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYCLES = 16
`endif
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              fetch_req,
    input  logic              pc_load,
    input  logic [ADDR_W-1:0] pc_load_val,
    instr_fetch_unit_if.master mem,
    output logic              ir_write_en,
    output logic [DATA_W-1:0] ir_data,
    output logic [ADDR_W-1:0] pc,
    output logic              busy,
    output logic              fetch_done,
    output logic              fetch_err
);

    fetch_state_t      state_q;
    fetch_state_t      state_d;
    logic [DATA_W-1:0] hold_q;
    logic              timeout;

`ifdef IFETCH_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] wait_cnt_q;
    logic             fetch_err_q;

    // Wait-state counter: zero on entry to WAIT, +1 for every WAIT cycle.
    always_ff @(posedge clock) begin
        if (reset) begin
            wait_cnt_q <= '0;
        end else if (state_q == REQ) begin
            wait_cnt_q <= '0;
        end else if (state_q == WAIT) begin
            wait_cnt_q <= wait_cnt_q + 1'b1;
        end
    end

    // The last allowed WAIT cycle passes without data; mem_valid still wins.
    assign timeout = (state_q == WAIT) && !mem.mem_valid &&
                     (wait_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

    // Registered one-cycle error pulse, lands in the first IDLE cycle.
    always_ff @(posedge clock) begin
        if (reset) begin
            fetch_err_q <= 1'b0;
        end else begin
            fetch_err_q <= timeout;
        end
    end

    assign fetch_err = fetch_err_q;
`else
    assign timeout   = 1'b0;
    assign fetch_err = 1'b0;
`endif

    // State register.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; REQ always advances so mem_valid there is ignored.
    always_comb begin
        // NOTE: assigning the default before the case guarantees every path
        // drives state_d, so no latch can be inferred.
        state_d = state_q;
        unique case (state_q)
            IDLE:  if (fetch_req) state_d = REQ;
            REQ:   state_d = WAIT;
            WAIT: begin
                if (mem.mem_valid) begin
                    state_d = WRITE;
                end else if (timeout) begin
                    state_d = IDLE;
                end
            end
            WRITE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Holding register: captures the memory word in WAIT, drives the IR.
    always_ff @(posedge clock) begin
        // NOTE: this data register is reset because it feeds ir_data
        // directly, which has to read zero out of reset.
        if (reset) begin
            hold_q <= '0;
        end else if ((state_q == WAIT) && mem.mem_valid) begin
            hold_q <= mem.mem_data;
        end
    end

    // pc loads only in IDLE (same cycle as an accepted fetch is fine, the
    // fetch then uses the new value) and advances when the IR is written.
    pc_counter #(
        .W(ADDR_W)
    ) u_pc_counter (
        .clock    (clock),
        .reset    (reset),
        .load     ((state_q == IDLE) && pc_load),
        .load_val (pc_load_val),
        .inc      (state_q == WRITE),
        .pc       (pc)
    );

    assign mem.mem_rd_en = (state_q == REQ);
    assign mem.mem_addr  = pc;
    assign ir_write_en   = (state_q == WRITE);
    assign fetch_done    = (state_q == WRITE);
    assign busy          = (state_q != IDLE);
    assign ir_data       = hold_q;

endmodule : instr_fetch_unit

// File: tb/tb_instr_fetch_unit.sv
// Directed self-checking bench for instr_fetch_unit with a scoreboard of
// expected IR writes. Timeout scenarios are built when IFETCH_TIMEOUT_EN
// is defined.
module tb_instr_fetch_unit;

    logic        clock = 1'b0;
    logic        reset;
    logic        fetch_req;
    logic        pc_load;
    logic [7:0]  pc_load_val;
    logic        ir_write_en;
    logic [15:0] ir_data;
    logic [7:0]  pc;
    logic        busy;
    logic        fetch_done;
    logic        fetch_err;

    instr_fetch_unit_if #(.DATA_W(16), .ADDR_W(8)) bus ();

    instr_fetch_unit dut (
        .clock       (clock),
        .reset       (reset),
        .fetch_req   (fetch_req),
        .pc_load     (pc_load),
        .pc_load_val (pc_load_val),
        .mem         (bus),
        .ir_write_en (ir_write_en),
        .ir_data     (ir_data),
        .pc          (pc),
        .busy        (busy),
        .fetch_done  (fetch_done),
        .fetch_err   (fetch_err)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [15:0] word;
        logic [7:0]  addr;
    } exp_t;

    exp_t        sb[$];
    int          vectors     = 0;
    int          miscompares = 0;
    int          cyc         = 0;
    int          err_pulses  = 0;
    logic [7:0]  pc_model    = 8'h00;
    logic [15:0] ir_q        = 16'h0000;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    always @(posedge clock) cyc <= cyc + 1;

    // Model of the IR register that loads on ir_write_en.
    always @(posedge clock) if (ir_write_en === 1'b1) ir_q <= ir_data;

    // Scoreboard: every IR write must match the oldest expected fetch.
    always @(negedge clock) begin
        if (fetch_err === 1'b1) err_pulses++;
        if (ir_write_en === 1'b1) begin
            if (sb.size() == 0) begin
                check("unexpected_ir_write", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("ir_data_at_write", ir_data, e.word);
                check("pc_at_write", pc, e.addr);
            end
        end
    end

    // One complete fetch. Enter just after a negedge in IDLE. lat is the
    // WAIT cycle (1-based) in which mem_valid is returned.
    task automatic run_fetch(input logic [15:0] word, input int lat,
                             input logic load, input logic [7:0] load_val,
                             input logic noise, input logic dead_req);
        logic [7:0] exp_addr;
        int         req_cyc;
        int         n;
        exp_addr = load ? load_val : pc_model;
        sb.push_back('{word: word, addr: exp_addr});
        fetch_req   = 1'b1;
        pc_load     = load;
        pc_load_val = load_val;
        req_cyc     = cyc;
        @(posedge clock); #1;
        fetch_req   = noise;
        pc_load     = noise;
        pc_load_val = 8'h77;
        if (dead_req) begin
            bus.mem_valid = 1'b1;
            bus.mem_data  = 16'hDEAD;
        end
        @(negedge clock);
        check("mem_rd_en_req", bus.mem_rd_en, 1'b1);
        check("mem_addr_req", bus.mem_addr, exp_addr);
        for (int i = 1; i <= lat; i++) begin
            @(posedge clock); #1;
            bus.mem_valid = (i == lat);
            bus.mem_data  = (i == lat) ? word : 16'hDEAD;
            if (i == lat) begin
                fetch_req = 1'b0;
                pc_load   = 1'b0;
            end
            if (i == 1) begin
                @(negedge clock);
                check("mem_rd_en_wait", bus.mem_rd_en, 1'b0);
            end
        end
        @(posedge clock); #1;
        bus.mem_valid = 1'b0;
        @(negedge clock);
        n = 0;
        while (ir_write_en !== 1'b1 && n < 40) begin
            @(negedge clock);
            n++;
        end
        check("write_seen", ir_write_en, 1'b1);
        check("latency", cyc - req_cyc + 1, lat + 3);
        check("fetch_done_with_write", fetch_done, 1'b1);
        check("busy_in_write", busy, 1'b1);
        pc_model = exp_addr + 8'd1;
        @(negedge clock);
        check("write_en_one_cycle", ir_write_en, 1'b0);
        check("fetch_done_one_cycle", fetch_done, 1'b0);
        check("pc_after", pc, pc_model);
        check("busy_after", busy, 1'b0);
        check("ir_data_held", ir_data, word);
        check("ir_out", ir_q, word);
        check("fetch_err_low", fetch_err, 1'b0);
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog expired observed=running expected=finished");
        $fatal(1);
    end

    initial begin
        int n;
        int req_cyc;
        reset         = 1'b1;
        fetch_req     = 1'b0;
        pc_load       = 1'b0;
        pc_load_val   = 8'h00;
        bus.mem_valid = 1'b0;
        bus.mem_data  = 16'h0000;
        repeat (2) @(posedge clock);
        @(negedge clock);
        check("rst_pc", pc, 8'h00);
        check("rst_ir_data", ir_data, 16'h0000);
        check("rst_busy", busy, 1'b0);
        check("rst_mem_rd_en", bus.mem_rd_en, 1'b0);
        check("rst_ir_write_en", ir_write_en, 1'b0);
        check("rst_fetch_done", fetch_done, 1'b0);
        check("rst_fetch_err", fetch_err, 1'b0);
        reset = 1'b0;
        @(negedge clock);

        // Basic fetch at pc=0, L=1.
        run_fetch(16'h0001, 1, 1'b0, 8'h00, 1'b0, 1'b0);

        // Load + fetch together; fetch uses 0xFF and pc wraps to 0x00.
        run_fetch(16'h0004, 1, 1'b1, 8'hFF, 1'b0, 1'b0);
        check("pc_wrap", pc, 8'h00);

        // Three back-to-back fetches with L=3 and requests/loads while busy.
        run_fetch(16'h0002, 3, 1'b0, 8'h00, 1'b1, 1'b0);
        run_fetch(16'h0003, 3, 1'b0, 8'h00, 1'b1, 1'b0);
        run_fetch(16'h0004, 3, 1'b0, 8'h00, 1'b1, 1'b0);
        check("pc_after_b2b", pc, 8'h03);

        // mem_valid in IDLE is ignored.
        bus.mem_valid = 1'b1;
        bus.mem_data  = 16'hDEAD;
        @(posedge clock); #1;
        bus.mem_valid = 1'b0;
        @(negedge clock);
        check("idle_valid_busy", busy, 1'b0);
        check("idle_valid_ir_data", ir_data, 16'h0004);
        check("idle_valid_pc", pc, 8'h03);

        // mem_valid during REQ is ignored; real data follows in WAIT cycle 2.
        run_fetch(16'h0005, 2, 1'b0, 8'h00, 1'b0, 1'b1);
        run_fetch(16'h0006, 1, 1'b0, 8'h00, 1'b0, 1'b0);
        check("pc_before_abort", pc, 8'h05);

        // Reset during WAIT aborts the fetch.
        fetch_req = 1'b1;
        @(posedge clock); #1;
        fetch_req = 1'b0;
        @(negedge clock);
        check("abort_req_addr", bus.mem_addr, 8'h05);
        @(negedge clock);
        check("abort_busy_wait", busy, 1'b1);
        reset = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
        @(negedge clock);
        pc_model = 8'h00;
        check("abort_pc", pc, 8'h00);
        check("abort_ir_data", ir_data, 16'h0000);
        check("abort_busy", busy, 1'b0);
        check("abort_mem_rd_en", bus.mem_rd_en, 1'b0);
        check("abort_ir_write_en", ir_write_en, 1'b0);
        check("abort_fetch_done", fetch_done, 1'b0);
        check("abort_fetch_err", fetch_err, 1'b0);
        bus.mem_valid = 1'b1;
        bus.mem_data  = 16'hBEEF;
        @(posedge clock); #1;
        bus.mem_valid = 1'b0;
        repeat (2) @(negedge clock);
        check("late_valid_busy", busy, 1'b0);
        check("late_valid_ir_data", ir_data, 16'h0000);
        check("late_valid_pc", pc, 8'h00);

`ifdef IFETCH_TIMEOUT_EN
        // Withhold mem_valid: 16 WAIT cycles then fetch_err and back to IDLE.
        err_pulses = 0;
        fetch_req  = 1'b1;
        req_cyc    = cyc;
        @(posedge clock); #1;
        fetch_req = 1'b0;
        @(negedge clock);
        n = 0;
        while (fetch_err !== 1'b1 && n < 40) begin
            @(negedge clock);
            n++;
        end
        check("timeout_err_seen", fetch_err, 1'b1);
        check("timeout_cycle", cyc - req_cyc, 18);
        check("timeout_busy", busy, 1'b0);
        @(negedge clock);
        check("timeout_err_pulse", fetch_err, 1'b0);
        check("timeout_err_count", err_pulses, 1);
        check("timeout_pc", pc, 8'h00);
        check("timeout_ir_data", ir_data, 16'h0000);

        // mem_valid in the 16th WAIT cycle beats the timeout.
        run_fetch(16'h0007, 16, 1'b0, 8'h00, 1'b0, 1'b0);
        check("timeout_race_err_count", err_pulses, 1);
`else
        n       = 0;
        req_cyc = 0;
`endif

        repeat (2) @(negedge clock);
        check("sb_drained", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule : tb_instr_fetch_unit
